// File: rtl/stream_split_fifo.sv
// stream_split_fifo: splits an N_CH-lane bus with per-lane valids into N_CH
// independent AXI-Stream masters, each behind a DEPTH-entry first-word
// fall-through FIFO with overflow pulse and saturating drop counter.
// rstn is asserted asynchronously; its release is expected to be already
// aligned to clk40 by the reset source.

module stream_split_fifo_ch #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk40,
  input  logic              rstn,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_vld,
  input  logic              clear,
  output logic [DATA_W-1:0] tdata,
  output logic              tvalid,
  input  logic              tready,
  output logic              full,
  output logic              overflow,
  output logic [CNT_W-1:0]  drops
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0]  ONE_P   = 1;
  localparam logic [AW:0]    ONE_C   = 1;
  localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count, count_nxt;
  logic              push, pop, drop;

  // Head word is visible whenever the FIFO is non-empty; zero otherwise.
  assign tvalid = (count != '0);
  assign tdata  = tvalid ? mem[rd_ptr] : '0;

  // A pop on the same edge frees the slot a push into a full FIFO needs.
  assign pop  = tvalid & tready;
  assign push = push_vld & (~full | pop);
  assign drop = push_vld & full & ~pop;

  // Next occupancy from the push/pop pair.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + ONE_C;
      2'b01:   count_nxt = count - ONE_C;
      default: count_nxt = count;
    endcase
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk40) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy, full flag, overflow pulse and saturating drop count.
  always_ff @(posedge clk40 or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
      drops    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE_P;
      if (pop)  rd_ptr <= rd_ptr + ONE_P;
      count    <= count_nxt;
      full     <= (count_nxt == DEPTH_C);
      overflow <= drop;
      // Clear first, then count, so a drop coinciding with clear is kept.
      if (clear)                        drops <= drop ? CNT_ONE : '0;
      else if (drop && drops != CNT_MAX) drops <= drops + CNT_ONE;
    end
  end
endmodule

module stream_split_fifo #(
  parameter int N_CH   = 12,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk40,
  input  logic                     rstn,
  input  logic [N_CH*DATA_W-1:0]   data_in,
  input  logic [N_CH-1:0]          valid_in,
  input  logic                     clear_counts,
  output logic [N_CH*DATA_W-1:0]   m_axis_tdata,
  output logic [N_CH-1:0]          m_axis_tvalid,
  input  logic [N_CH-1:0]          m_axis_tready,
  output logic [N_CH-1:0]          fifo_full,
  output logic [N_CH-1:0]          overflow,
  output logic [N_CH*CNT_W-1:0]    drop_count
);
  // One fully independent FIFO channel per lane.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    stream_split_fifo_ch #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk40    (clk40),
      .rstn     (rstn),
      .push_data(data_in[i*DATA_W +: DATA_W]),
      .push_vld (valid_in[i]),
      .clear    (clear_counts),
      .tdata    (m_axis_tdata[i*DATA_W +: DATA_W]),
      .tvalid   (m_axis_tvalid[i]),
      .tready   (m_axis_tready[i]),
      .full     (fifo_full[i]),
      .overflow (overflow[i]),
      .drops    (drop_count[i*CNT_W +: CNT_W])
    );
  end
endmodule
